ascii_write_receiver: RTL and testbench

Receiving end of the character-display write port driven by the processor core and its register-dump debug FSM. The block captures `{char, attr}` writes on `wr_en`/`wr_addr`/`wr_data`, buffers them in a small FIFO, and drains them into the character-cell RAM port whenever the VGA scanout side is not using that port. It also reports back-pressure (`full`) and sticky error status, so writers never lose characters silently.

---
 rtl/ascii_rx_pkg.sv | 33 +++
 rtl/ascii_rx_fifo.sv | 64 ++++++
 rtl/ascii_write_receiver.sv | 142 ++++++++++++++
 tb/tb_ascii_write_receiver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_rx_pkg.sv
// Shared types and constants for the character-display write receiver.
package ascii_rx_pkg;

    localparam int unsigned COLS      = 80;
    localparam int unsigned ROWS      = 60;
    localparam int unsigned CELLS_DEF = COLS * ROWS;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned ATTR_W    = 24;

    // One queued cell write; field order matches {wr_addr, wr_data}.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CHAR_W-1:0] chr;
        logic [ATTR_W-1:0] attr;
    } cell_entry_t;

    typedef enum logic {
        IDLE,
        WRITE
    } drain_state_t;

    function automatic cell_entry_t make_entry(input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] data);
        cell_entry_t e;
        e.addr = addr;
        e.chr  = data[31:24];
        e.attr = data[23:0];
        return e;
    endfunction

endpackage

// File: rtl/ascii_rx_fifo.sv
// Synchronous FIFO with registered full/empty/count; head is a combinational peek.
module ascii_rx_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = logic [44:0],
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head_c,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_next;
    logic            push_ok;
    logic            pop_ok;

    // A push is refused while full even if a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == CW'(0));
        end
    end

endmodule

// File: rtl/ascii_write_receiver.sv
// Buffers {char, attr} display writes and drains them into the cell RAM around scanout.
// Optional ASCII_RX_DEDUP_EN: collapse held/repeated writes into one FIFO entry.
import ascii_rx_pkg::*;

module ascii_write_receiver #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CELLS = CELLS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                scan_busy,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                range_err,
    output logic [7:0]          drop_count,
    output logic                cell_we,
    output logic [ADDR_W-1:0]   cell_addr,
    output logic [CHAR_W-1:0]   cell_char,
    output logic [ATTR_W-1:0]   cell_attr
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          capture_c;
    logic          in_range_c;
    logic          range_drop_c;
    logic          ovf_drop_c;
    logic          push_c;
    logic          pop_c;
    logic [CW-1:0] fifo_count;
    cell_entry_t   head_c;
    drain_state_t  state;

`ifdef ASCII_RX_DEDUP_EN
    logic              wr_en_q;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;

    // New write on a rising enable or whenever the pair differs from the last capture.
    assign capture_c = wr_en && (!wr_en_q || (wr_addr != last_addr) || (wr_data != last_data));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            wr_en_q <= wr_en;
            if (capture_c) begin
                last_addr <= wr_addr;
                last_data <= wr_data;
            end
        end
    end
`else
    assign capture_c = wr_en;
`endif

    // Range check takes priority; fullness uses the count before this cycle's pop.
    assign in_range_c   = (32'(wr_addr) < CELLS);
    assign range_drop_c = capture_c && !in_range_c;
    assign ovf_drop_c   = capture_c && in_range_c && (fifo_count >= CW'(DEPTH));
    assign push_c       = capture_c && in_range_c && !(fifo_count >= CW'(DEPTH));

    always_comb begin
        pop_c = 1'b0;
        case (state)
            IDLE, WRITE: pop_c = !empty && !scan_busy;
            default:     pop_c = 1'b0;
        endcase
    end

    ascii_rx_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cell_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (make_entry(wr_addr, wr_data)),
        .pop       (pop_c),
        .head_c    (head_c),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Sticky error flags and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            range_err  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (range_drop_c) range_err <= 1'b1;
            if (ovf_drop_c)   overflow  <= 1'b1;
            if ((range_drop_c || ovf_drop_c) && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'(1);
            end
        end
    end

    // Drain FSM: a popped head is always written on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cell_we   <= 1'b0;
            cell_addr <= '0;
            cell_char <= '0;
            cell_attr <= '0;
        end else begin
            cell_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        state     <= WRITE;
                        cell_we   <= 1'b1;
                        cell_addr <= head_c.addr;
                        cell_char <= head_c.chr;
                        cell_attr <= head_c.attr;
                    end
                end
                WRITE: begin
                    if (pop_c) begin
                        cell_we   <= 1'b1;
                        cell_addr <= head_c.addr;
                        cell_char <= head_c.chr;
                        cell_attr <= head_c.attr;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_write_receiver.sv
// Directed self-checking bench for ascii_write_receiver.
module tb_ascii_write_receiver;
    import ascii_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [31:0] wr_data;
    logic        scan_busy;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        range_err;
    logic [7:0]  drop_count;
    logic        cell_we;
    logic [12:0] cell_addr;
    logic [7:0]  cell_char;
    logic [23:0] cell_attr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_viol = 0;
    logic sb_edge = 1'b0;
    cell_entry_t log_q[$];
    int log_cyc[$];

    ascii_write_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .scan_busy  (scan_busy),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .range_err  (range_err),
        .drop_count (drop_count),
        .cell_we    (cell_we),
        .cell_addr  (cell_addr),
        .cell_char  (cell_char),
        .cell_attr  (cell_attr)
    );

    always #5 clk = ~clk;

    // Record every RAM write and the scan_busy value at the edge that launched it.
    always begin
        @(posedge clk);
        sb_edge = scan_busy;
        cyc++;
        #1;
        if (cell_we) begin
            log_q.push_back('{cell_addr, cell_char, cell_attr});
            log_cyc.push_back(cyc);
            if (sb_edge) busy_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [12:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick(1);
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; scan_busy = 1'b0;
        tick(2);
        check("rst_full", 64'(full), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_range_err", 64'(range_err), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_cell_we", 64'(cell_we), 64'd0);
        check("rst_cell_addr", 64'(cell_addr), 64'd0);
        check("rst_cell_char", 64'(cell_char), 64'd0);
        check("rst_cell_attr", 64'(cell_attr), 64'd0);
        rst = 1'b0;
        tick(1);

        // Single write: strobe two edges after the capture.
        put(13'd81, 32'h41FF_FFFF);
        wr_en = 1'b0;
        check("single_empty_after_push", 64'(empty), 64'd0);
        check("single_no_early_we", 64'(cell_we), 64'd0);
        tick(1);
        check("single_we", 64'(cell_we), 64'd1);
        check("single_addr", 64'(cell_addr), 64'd81);
        check("single_char", 64'(cell_char), 64'h41);
        check("single_attr", 64'(cell_attr), 64'hFF_FFFF);
        check("single_empty_after_pop", 64'(empty), 64'd1);
        tick(1);
        check("single_we_drop", 64'(cell_we), 64'd0);

        // Held enable across a changing address.
        clear_log();
        for (int i = 0; i < 12; i++) begin
            put(13'(i / 3), 32'h4200_0001);
        end
        wr_en = 1'b0;
        tick(6);
`ifdef ASCII_RX_DEDUP_EN
        check("held_count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("held_addr", 64'(log_q[i].addr), 64'(i));
        end
`else
        check("held_count", 64'(log_q.size()), 64'd12);
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            check("held_addr", 64'(log_q[i].addr), 64'(i / 3));
        end
`endif
        check("held_no_drop", 64'(drop_count), 64'd0);

        // Overflow: 10 writes into 8 slots while scanout blocks the port.
        scan_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            put(13'(100 + i), {8'h50 + 8'(i), 24'h0000AA});
        end
        wr_en = 1'b0;
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop_count", 64'(drop_count), 64'd2);
        check("ovf_no_we_while_busy", 64'(cell_we), 64'd0);
        clear_log();
        scan_busy = 1'b0;
        tick(12);
        check("ovf_drain_count", 64'(log_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            check("ovf_drain_addr", 64'(log_q[i].addr), 64'(100 + i));
            check("ovf_drain_char", 64'(log_q[i].chr), 64'(8'h50 + 8'(i)));
        end
        if (log_q.size() == 8) check("ovf_back_to_back", 64'(log_cyc[7] - log_cyc[0]), 64'd7);
        check("ovf_empty_after", 64'(empty), 64'd1);
        check("ovf_full_after", 64'(full), 64'd0);

        // Range: 4800 dropped, 4799 accepted.
        clear_log();
        put(13'd4800, 32'h5800_0000);
        wr_en = 1'b0;
        check("range_flag", 64'(range_err), 64'd1);
        check("range_drop_count", 64'(drop_count), 64'd3);
        check("range_no_entry", 64'(empty), 64'd1);
        put(13'd4799, 32'h5A12_3456);
        wr_en = 1'b0;
        tick(3);
        check("range_last_count", 64'(log_q.size()), 64'd1);
        if (log_q.size() >= 1) begin
            check("range_last_addr", 64'(log_q[0].addr), 64'd4799);
            check("range_last_char", 64'(log_q[0].chr), 64'h5A);
            check("range_last_attr", 64'(log_q[0].attr), 64'h12_3456);
        end

        // Scan contention: alternating scan_busy.
        scan_busy = 1'b1;
        busy_viol = 0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            put(13'(200 + i), {8'h60 + 8'(i), 24'h000100});
        end
        wr_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            scan_busy = (k % 2 == 0);
            tick(1);
        end
        scan_busy = 1'b0;
        tick(3);
        check("scan_busy_violations", 64'(busy_viol), 64'd0);
        check("scan_count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("scan_addr", 64'(log_q[i].addr), 64'(200 + i));
        end

        // Reset in the middle of a drain.
        scan_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            put(13'(300 + i), {8'h70 + 8'(i), 24'h000200});
        end
        wr_en = 1'b0;
        clear_log();
        scan_busy = 1'b0;
        for (int k = 0; k < 20 && log_q.size() < 2; k++) tick(1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_cell_we", 64'(cell_we), 64'd0);
        check("mid_rst_empty", 64'(empty), 64'd1);
        check("mid_rst_full", 64'(full), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_range_err", 64'(range_err), 64'd0);
        check("mid_rst_drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        tick(10);
        check("mid_rst_write_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() >= 2) check("mid_rst_second_addr", 64'(log_q[1].addr), 64'd301);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
